// File: rtl/cg_pkg.sv
// Shared definitions for the clock-gating controller: per-channel FSM
// state encodings and parameter defaults.
`default_nettype none

package cg_pkg;

  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_WAKE  = 2'd1,
    CG_ON    = 2'd2,
    CG_DRAIN = 2'd3
  } cg_state_e;

  localparam int CG_NUM_CH_DEF   = 3;
  localparam int CG_IDLE_W_DEF   = 8;
  localparam int CG_WAKE_CYC_DEF = 2;
  localparam int CG_WAKE_W       = 4;

endpackage

`default_nettype wire

// File: rtl/cg_cell.sv
// Glitch-free clock gate: enable latch transparent while clk is low,
// ANDed with clk so the enable can only change while the output is low.
`default_nettype none

module cg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat <= en | test_en;
  end

  assign gclk = clk & en_lat;

endmodule

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel OFF/WAKE/ON/DRAIN FSM
// with wake delay, idle auto-gating and a glitch-free gate cell per channel.
`default_nettype none

module clk_gate_ctrl
  import cg_pkg::*;
#(
  parameter int NUM_CH   = CG_NUM_CH_DEF,
  parameter int IDLE_W   = CG_IDLE_W_DEF,
  parameter int WAKE_CYC = CG_WAKE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_en,
  input  logic              test_en,
  input  logic [IDLE_W-1:0] idle_limit,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_clk,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] ch_on
);

  // Counter is loaded with WAKE_CYC-1 so that WAKE lasts exactly WAKE_CYC cycles.
  localparam logic [CG_WAKE_W-1:0] WAKE_LOAD = CG_WAKE_W'(WAKE_CYC - 1);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      cg_state_e            state_q, state_d;
      logic [CG_WAKE_W-1:0] wake_q, wake_d;
      logic [IDLE_W-1:0]    idle_q, idle_d;
      logic                 en_q, ready_q;
      logic                 run_req;
      logic                 idle_cyc;

      assign run_req  = ch_req[i] & global_en;
      assign idle_cyc = ~ch_req[i] & ~ch_busy[i];

      always_comb begin
        state_d = state_q;
        wake_d  = '0;
        idle_d  = '0;
        case (state_q)
          CG_OFF: begin
            if (run_req) begin
              state_d = CG_WAKE;
              wake_d  = WAKE_LOAD;
            end
          end
          CG_WAKE: begin
            if (!global_en) begin
              state_d = CG_OFF;
            end else if (wake_q == '0) begin
              state_d = CG_ON;
            end else begin
              wake_d = wake_q - 1'b1;
            end
          end
          CG_ON: begin
            if (!global_en || ((idle_limit != '0) && (idle_q == idle_limit))) begin
              state_d = CG_DRAIN;
            end else if (idle_cyc) begin
              idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
            end
          end
          CG_DRAIN: begin
            state_d = run_req ? CG_ON : CG_OFF;
          end
          default: begin
            state_d = CG_OFF;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= CG_OFF;
          wake_q  <= '0;
          idle_q  <= '0;
          en_q    <= 1'b0;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          wake_q  <= wake_d;
          idle_q  <= idle_d;
          en_q    <= (state_d != CG_OFF);
          ready_q <= (state_d == CG_ON);
        end
      end

      assign ch_on[i]    = en_q;
      assign ch_ready[i] = ready_q;

      cg_cell u_cell (
        .clk     (clk),
        .en      (en_q),
        .test_en (test_en),
        .gclk    (ch_clk[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus random
// stimulus, all checked every cycle against a behavioural channel model.
`default_nettype none

module tb_clk_gate_ctrl;

  localparam int NCH  = 3;
  localparam int IW   = 8;
  localparam int WC   = 2;
  localparam int IMAX = (1 << IW) - 1;

  localparam int M_OFF   = 0;
  localparam int M_WAKE  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           global_en;
  logic           test_en;
  logic [IW-1:0]  idle_limit;
  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_busy;
  logic [NCH-1:0] ch_clk;
  logic [NCH-1:0] ch_ready;
  logic [NCH-1:0] ch_on;

  int checks = 0;
  int errors = 0;

  int m_mode [NCH];
  int m_age  [NCH];
  int m_idle [NCH];

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NUM_CH   (NCH),
    .IDLE_W   (IW),
    .WAKE_CYC (WC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .global_en  (global_en),
    .test_en    (test_en),
    .idle_limit (idle_limit),
    .ch_req     (ch_req),
    .ch_busy    (ch_busy),
    .ch_clk     (ch_clk),
    .ch_ready   (ch_ready),
    .ch_on      (ch_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_update();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_mode[i] = M_OFF;
        m_age[i]  = 0;
        m_idle[i] = 0;
      end else begin
        case (m_mode[i])
          M_OFF: begin
            if (ch_req[i] && global_en) begin
              m_mode[i] = M_WAKE;
              m_age[i]  = 0;
            end
          end
          M_WAKE: begin
            if (!global_en) begin
              m_mode[i] = M_OFF;
            end else begin
              m_age[i]++;
              if (m_age[i] == WC) begin
                m_mode[i] = M_RUN;
                m_idle[i] = 0;
              end
            end
          end
          M_RUN: begin
            if (!global_en || (idle_limit != 0 && m_idle[i] == int'(idle_limit))) begin
              m_mode[i] = M_FLUSH;
              m_idle[i] = 0;
            end else if (!ch_req[i] && !ch_busy[i]) begin
              m_idle[i] = (m_idle[i] < IMAX) ? m_idle[i] + 1 : IMAX;
            end else begin
              m_idle[i] = 0;
            end
          end
          default: begin
            if (ch_req[i] && global_en) begin
              m_mode[i] = M_RUN;
              m_idle[i] = 0;
            end else begin
              m_mode[i] = M_OFF;
            end
          end
        endcase
      end
    end
  endfunction

  function automatic logic [NCH-1:0] exp_on();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (m_mode[i] != M_OFF);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (m_mode[i] == M_RUN);
    return v;
  endfunction

  // One clock cycle: inputs are held from the previous falling edge, the gate
  // latch captures the pre-edge enable during the low phase.
  task automatic step();
    logic [NCH-1:0] exp_clk;
    exp_clk = exp_on() | {NCH{test_en}};
    model_update();
    @(posedge clk);
    #1;
    check("ch_on", ch_on, exp_on());
    check("ch_ready", ch_ready, exp_ready());
    check("ch_clk_high", ch_clk, exp_clk);
    @(negedge clk);
    #1;
    check("ch_clk_low", ch_clk, '0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = M_OFF;
      m_age[i]  = 0;
      m_idle[i] = 0;
    end
    rst = 1'b1; global_en = 1'b0; test_en = 1'b0;
    idle_limit = '0; ch_req = '0; ch_busy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    step();
    check("reset_on", ch_on, '0);
    check("reset_ready", ch_ready, '0);

    rst = 1'b0; global_en = 1'b1; idle_limit = 8'd4;
    step(); step();

    // Wake latency and idle auto-gating on channel 0
    ch_req[0] = 1'b1; step(); ch_req[0] = 1'b0;
    check("wake_on0", 32'(ch_on[0]), 32'd1);
    check("wake_rdy0", 32'(ch_ready[0]), 32'd0);
    step();
    check("wake_mid_rdy0", 32'(ch_ready[0]), 32'd0);
    step();
    check("ready_latency0", 32'(ch_ready[0]), 32'd1);
    repeat (4) step();
    check("idle_still_on0", 32'(ch_ready[0]), 32'd1);
    step();
    check("drain_rdy0", 32'(ch_ready[0]), 32'd0);
    check("drain_on0", 32'(ch_on[0]), 32'd1);
    step();
    check("off_on0", 32'(ch_on[0]), 32'd0);

    // Re-request during DRAIN returns straight to ON
    ch_req[1] = 1'b1; step(); ch_req[1] = 1'b0;
    step(); step();
    repeat (5) step();
    check("drain_rdy1", 32'(ch_ready[1]), 32'd0);
    check("drain_on1", 32'(ch_on[1]), 32'd1);
    ch_req[1] = 1'b1; step(); ch_req[1] = 1'b0;
    check("drain_rerun1", 32'(ch_ready[1]), 32'd1);
    global_en = 1'b0; step(); step(); global_en = 1'b1;

    // global_en drop with ch0 in ON and ch1 in WAKE
    ch_req[0] = 1'b1; step(); step(); step();
    ch_req[1] = 1'b1; step();
    global_en = 1'b0; step();
    check("gdrop_drain_rdy0", 32'(ch_ready[0]), 32'd0);
    check("gdrop_drain_on0", 32'(ch_on[0]), 32'd1);
    check("gdrop_abort_on1", 32'(ch_on[1]), 32'd0);
    step();
    check("gdrop_off0", 32'(ch_on[0]), 32'd0);
    ch_req = '0; global_en = 1'b1;

    // Test override with everything off
    test_en = 1'b1; step(); step();
    check("test_on", ch_on, '0);
    check("test_ready", ch_ready, '0);
    test_en = 1'b0; step();

    // Auto-gating disabled, reset in the middle
    idle_limit = '0;
    ch_req[2] = 1'b1; step(); step(); step(); ch_req[2] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 149) check("nolimit_rdy2", 32'(ch_ready[2]), 32'd1);
      if (k == 150) rst = 1'b1;
      step();
      if (k == 150) begin
        rst = 1'b0;
        check("midrst_on", ch_on, '0);
        check("midrst_ready", ch_ready, '0);
      end
    end

    // Idle counter saturation, then a live idle_limit change
    ch_req[2] = 1'b1; step(); step(); step(); ch_req[2] = 1'b0;
    repeat (300) step();
    check("sat_still_on2", 32'(ch_ready[2]), 32'd1);
    idle_limit = 8'hFF; step();
    check("sat_drain2", 32'(ch_ready[2]), 32'd0);
    idle_limit = 8'd3; step(); step();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      global_en = ($urandom_range(0, 9) != 0);
      test_en   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NCH; i++) begin
        ch_req[i]  = ($urandom_range(0, 3) == 0);
        ch_busy[i] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 49) == 0) idle_limit = IW'($urandom_range(0, 6));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of independently gated clock channels (1..16).
REQ-002 The block SHALL have parameter IDLE_W, default 8, giving the idle-counter width.
REQ-003 The block SHALL have parameter WAKE_CYC, default 2, giving the clock-running cycles before a channel reports ready (1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: source clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port global_en, input, 1 bit: master enable for all channels.
REQ-007 The block SHALL have port test_en, input, 1 bit: scan/test override that forces all gated clocks running.
REQ-008 The block SHALL have port idle_limit, input, IDLE_W bits: idle cycles before auto-gating; 0 disables auto-gating.
REQ-009 The block SHALL have port ch_req, input, NUM_CH bits: per-channel request to run.
REQ-010 The block SHALL have port ch_busy, input, NUM_CH bits: per-channel activity from the consumer, sampled with clk.
REQ-011 The block SHALL have port ch_clk, output, NUM_CH bits: glitch-free gated clocks.
REQ-012 The block SHALL have port ch_ready, output, NUM_CH bits: channel clock stable and usable.
REQ-013 The block SHALL have port ch_on, output, NUM_CH bits: registered clock-enable state per channel.

Function
REQ-014 Each channel SHALL run an independent FSM with states OFF, WAKE, ON and DRAIN.
REQ-015 OFF SHALL transition to WAKE when ch_req[i] & global_en; otherwise the channel SHALL stay in OFF with its enable at 0.
REQ-016 On entry to WAKE, enable SHALL be 1 and a wake counter SHALL be loaded; after exactly WAKE_CYC cycles in WAKE the channel SHALL go to ON.
REQ-017 ch_ready[i] SHALL be 1 only in ON, asserted the first cycle in ON; latency from ch_req sampled to ch_ready is WAKE_CYC+1 cycles.
REQ-018 In ON, the idle counter SHALL increment each cycle with !ch_req[i] & !ch_busy[i], and SHALL clear otherwise.
REQ-019 The idle counter SHALL saturate at all-ones and never wrap.
REQ-020 ON SHALL go to DRAIN when idle_limit != 0 and the idle count equals idle_limit, or when global_en = 0.
REQ-021 DRAIN SHALL last exactly one cycle, with ch_ready = 0 and enable still 1 to flush the consumer pipeline, then go to OFF.
REQ-022 ch_req[i] & global_en in DRAIN SHALL return the channel to ON (no re-wake) with the idle counter cleared.
REQ-023 global_en = 0 in WAKE SHALL abort to OFF the next cycle.
REQ-024 ch_on[i] SHALL equal the registered enable; ch_clk[i] SHALL be clk AND a latch of (enable | test_en) that is transparent while clk is low.
REQ-025 test_en SHALL affect only ch_clk, never FSM state, ch_ready or ch_on.
REQ-026 A change of idle_limit SHALL take effect on the next comparison, with no counter reset.

Reset
REQ-027 On rst, all FSMs SHALL go to OFF, and all idle and wake counters and enables SHALL be 0.
REQ-028 On rst, ch_ready and ch_on SHALL be 0, and ch_clk SHALL be held low from the next clk low phase unless test_en is 1.
REQ-029 rst asserted mid-WAKE, ON or DRAIN SHALL override all other transitions in that cycle.

Structure
REQ-030 Shared package cg_pkg SHALL hold the 2-bit state encodings (OFF=0, WAKE=1, ON=2, DRAIN=3) and the parameter defaults.
REQ-031 One sub-module cg_cell (latch plus AND, inputs clk/en/test_en, output gclk) SHALL be instantiated per channel; FSMs SHALL be generated per channel in the top.

Verification
REQ-032 WAKE_CYC=2, pulse ch_req[0] at cycle 10 -> ch_on[0]=1 at cycle 11, ch_ready[0]=1 at cycle 13, ch_clk[0] toggling from cycle 11.
REQ-033 idle_limit=4, ch_0 in ON, busy/req low -> DRAIN after 4 idle cycles (ready=0, on=1), then OFF (on=0, ch_clk[0] low).
REQ-034 ch_req[1] reasserted during DRAIN -> ch_ready[1] back to 1 the next cycle, no WAKE state visited.
REQ-035 global_en dropped with ch0 in ON and ch1 in WAKE -> ch0 goes DRAIN then OFF; ch1 goes OFF in 1 cycle.
REQ-036 test_en=1 with all channels OFF -> all ch_clk toggle, ch_on=0, ch_ready=0.
REQ-037 idle_limit=0, ch2 in ON and idle for 300 cycles -> stays ON; rst at cycle 150 -> all outputs 0 next cycle.
